// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a 16x4 registered-read RAM, with a one-entry output register.
// Optional sticky overflow flag when FIFO_OVF_FLAG_EN is defined; sustained rate is one word per two cycles.
module ram_fifo_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD
   } rd_state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   rd_state_t         rd_state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   mem_count;
   logic              rd_pending;
   logic              push;
   logic              issue;
   logic              pop;

   assign full     = (mem_count == DEPTH_C);
   assign in_ready = !full;
   // Gated by reset so nothing reaches the RAM while reset is held.
   assign push     = in_valid & in_ready & reset;
   assign pop      = out_valid & out_ready;
   assign issue    = reset & (mem_count != '0) & !rd_pending & (!out_valid | out_ready);

   assign ram_we    = push;
   assign ram_waddr = wr_ptr;
   assign ram_wdata = in_data;
   assign ram_re    = issue;
   assign ram_raddr = rd_ptr;

   assign count = mem_count + (ADDR_W+1)'(rd_pending) + (ADDR_W+1)'(out_valid);
   assign empty = (count == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_state   <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_count  <= '0;
         rd_pending <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (issue)
            rd_ptr <= rd_ptr + ADDR_W'(1);

         case ({push, issue})
            2'b10:   mem_count <= mem_count + (ADDR_W+1)'(1);
            2'b01:   mem_count <= mem_count - (ADDR_W+1)'(1);
            default: mem_count <= mem_count;
         endcase

         // issue already implies no read is in flight, so this also retires the pending read
         rd_pending <= issue;

         if (rd_pending) begin
            out_data  <= ram_rdata;
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end

         case (rd_state)
            S_IDLE:  if (issue) rd_state <= S_FETCH;
            S_FETCH: rd_state <= S_HOLD;
            S_HOLD:  if (pop) rd_state <= (mem_count != '0) ? S_FETCH : S_IDLE;
            default: rd_state <= S_IDLE;
         endcase
      end
   end

`ifdef FIFO_OVF_FLAG_EN
   logic overflow_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow_q <= 1'b0;
      else if (in_valid & full)
         overflow_q <= 1'b1;
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 16x4 registered-read RAM.
module tb_ram_fifo_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       ram_we;
   logic [3:0] ram_waddr;
   logic [3:0] ram_wdata;
   logic       ram_re;
   logic [3:0] ram_raddr;
   logic [3:0] ram_rdata;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;

   int vectors = 0;
   int errors  = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mem[16];

`ifdef FIFO_OVF_FLAG_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   ram_fifo_ctrl dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .count(count), .full(full), .empty(empty), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output word must match the oldest pushed word.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %0h with empty scoreboard", out_data);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL out_word: got %0h expected %0h", out_data, e);
            end
         end
      end
   end

   task automatic push_word(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(d);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
      end
      check("push_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 500; t++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && empty) return;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rst_empty", empty, 1); check("rst_full", full, 0);
      check("rst_in_ready", in_ready, 1); check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0); check("rst_ram_we", ram_we, 0);
      check("rst_ram_re", ram_re, 0); check("rst_overflow", overflow, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("idle_count", count, 0); check("idle_ram_re", ram_re, 0);

      // First-word latency
      out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hA; exp_q.push_back(4'hA);
      #1;
      check("lat_ram_we", ram_we, 1); check("lat_waddr", ram_waddr, 0);
      check("lat_wdata", ram_wdata, 4'hA);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_ram_re", ram_re, 1); check("lat_raddr", ram_raddr, 0);
      check("lat_ov_n1", out_valid, 0);
      @(posedge clk); #1;
      check("lat_ov_n2_pending", out_valid, 0); check("lat_count_fetch", count, 1);
      @(posedge clk); #1;
      check("lat_out_valid", out_valid, 1); check("lat_out_data", out_data, 4'hA);
      @(posedge clk); #1;
      check("lat_pop_count", count, 0); check("lat_pop_empty", empty, 1);

      // Fill to 17 words with the consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) push_word(4'(i));
      @(posedge clk); #1;
      check("fill_count", count, 17); check("fill_full", full, 1);
      check("fill_in_ready", in_ready, 0); check("fill_out_valid", out_valid, 1);
      check("fill_out_data", out_data, 4'h0);
      in_valid = 1'b1; in_data = 4'h9;
      #1;
      check("full_ram_we", ram_we, 0);
      repeat (3) @(posedge clk); #1;
      check("full_overflow", overflow, OVF_EXP);
      check("full_hold_data", out_data, 4'h0); check("full_hold_count", count, 17);
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      check("drain_empty", empty, 1); check("drain_overflow", overflow, OVF_EXP);

      // Pointer wrap with a toggling consumer
      fork
         for (int i = 0; i < 20; i++) push_word(4'(i * 3 + 1));
         for (int c = 0; c < 90; c++) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
         end
      join
      out_ready = 1'b1;
      wait_drain();
      check("wrap_queue", exp_q.size(), 0);

      // Asynchronous reset while a read is in flight
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push_word(4'(i));
      out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h6; exp_q.push_back(4'h6);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      check("mid_count", count, 5); check("mid_out_valid", out_valid, 0);
      #1 reset = 1'b0;
      #1;
      check("arst_count", count, 0); check("arst_empty", empty, 1);
      check("arst_full", full, 0); check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0); check("arst_out_data", out_data, 0);
      check("arst_overflow", overflow, 0); check("arst_ram_re", ram_re, 0);
      in_valid = 1'b1; in_data = 4'h7;
      #1;
      check("arst_ram_we", ram_we, 0);
      in_valid = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      in_valid = 1'b1; in_data = 4'h3; exp_q.push_back(4'h3);
      #1;
      check("post_rst_we", ram_we, 1); check("post_rst_waddr", ram_waddr, 0);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      wait_drain();
      check("final_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Controller that turns the 16x4 flip-flop RAM into a first-in first-out buffer. It sits directly upstream of the RAM and drives its write/read enables, addresses and write data. It also captures the RAM's registered read data into a one-entry output register. The producer side uses a valid/ready handshake, and so does the consumer side.

Parameters:
DATA_W, 4, word width; must match RAM data width.
ADDR_W, 4, RAM address width.
DEPTH, 16, RAM entries; fixed to 2**ADDR_W.

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low; 0 clears all state immediately.
in_valid  in  1  producer offers in_data.
in_ready  out  1  controller can accept a word.
in_data  in  DATA_W  word to store.
out_valid  out  1  out_data holds the oldest word.
out_ready  in  1  consumer takes out_data.
out_data  out  DATA_W  head-of-FIFO word (registered).
ram_we  out  1  RAM write enable.
ram_waddr  out  ADDR_W  RAM write address.
ram_wdata  out  DATA_W  RAM write data.
ram_re  out  1  RAM read enable.
ram_raddr  out  ADDR_W  RAM read address.
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re.
count  out  ADDR_W+1  words in RAM + words in flight + output register.
full  out  1  RAM holds DEPTH words.
empty  out  1  count==0.
overflow  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=rd_ptr=0, mem_count=0, rd_pending=0.
  - out_valid=0, out_data=0, count=0, overflow=0.
  - Outputs: empty=1, full=0, in_ready=1.
  - Reset mid-transfer discards all stored data; no RAM write or read is issued while reset=0.
- Push:
  - in_ready = !full, where full = (mem_count==DEPTH).
  - push = in_valid & in_ready.
  - ram_we=push, ram_waddr=wr_ptr, ram_wdata=in_data (all combinational).
  - wr_ptr increments on push and wraps 15->0.
- Read issue:
  - issue = (mem_count!=0) & !rd_pending & (!out_valid | out_ready).
  - ram_re=issue, ram_raddr=rd_ptr (combinational).
  - On issue: rd_ptr increments (wraps 15->0) and rd_pending is set for the next cycle.
- Capture: when rd_pending=1, out_data<=ram_rdata and out_valid<=1 at the end of that cycle; rd_pending clears.
- Pop: out_valid & out_ready. out_valid clears unless a capture occurs in the same cycle.
- Read-side state machine:
  - IDLE: out empty, nothing in flight.
  - FETCH: rd_pending=1.
  - HOLD: out_valid=1, nothing in flight.
  - Transitions: IDLE->FETCH on issue; FETCH->HOLD always; HOLD->FETCH on pop with mem_count!=0; HOLD->IDLE on pop with mem_count==0.
- Throughput: sustained rate is one word per 2 cycles.
- First-word latency: push at edge N gives out_valid=1 after edge N+2.
- mem_count: +1 on push, -1 on issue, unchanged when both occur.
- count = mem_count + rd_pending + out_valid. Maximum is DEPTH+1 = 17.
- Boundaries:
  - No read is issued when mem_count==0, so there is never same-address read/write in one cycle.
  - Push and issue in the same cycle when full is legal: in_ready reflects registered full, so the push is refused that cycle.
  - in_data is ignored when in_ready=0.
  - out_data holds its value while out_valid=1 and out_ready=0.

Optional Feature:
FIFO_OVF_FLAG_EN
- Defined: overflow is set on any cycle with in_valid=1 & full=1. It stays set until reset.
- Undefined: overflow is tied to 0 and no extra state exists.

Test Plan:
- Reset then idle -> empty=1, full=0, in_ready=1, count=0, out_valid=0, ram_we=ram_re=0.
- Push 0xA at edge N with out_ready=1 -> ram_we=1, ram_waddr=0 in cycle N. ram_re=1, ram_raddr=0 in cycle N+1. out_valid=1, out_data=0xA after edge N+2. Pop drops count to 0.
- Push 0x0..0xF with out_ready=0 -> 0x0 is fetched to the output register. After 16 more pushes total 17 words are held: count=17, full=1, in_ready=0. Draining yields 0x0..0xF in order plus later data, with no loss.
- Push 20 words with interleaved pops (out_ready toggling) -> wr_ptr/rd_ptr wrap past 15 and output order is preserved.
- Assert reset=0 asynchronously while rd_pending=1 and count=5 -> all outputs return to reset values before the next edge. The first push after release goes to ram_waddr=0.
- With FIFO_OVF_FLAG_EN defined: hold in_valid=1 while full -> overflow=1, still 1 after drain. Without the macro: overflow=0 in the same stimulus.
